// File: rtl/k_wta_inhibition.sv
// k-winner-take-all lateral inhibition for one TNN column.
// Within each gamma window, the first K distinct neurons to spike become
// winners. Every later spike is inhibited until the next gamma_start.
// Optional feature: define WTA_ROTATE_PRIORITY_EN to rotate tie-break priority
// between windows. When it is undefined, the lowest index always wins a tie.
module k_wta_inhibition #(
  parameter int N = 16,
  parameter int T = 8,
  parameter int K = 1,
  localparam int TW = $clog2(T),
  localparam int IW = $clog2(N),
  localparam int CW = $clog2(K + 1)
) (
  input  logic          clk,
  input  logic          rst_l,
  input  logic          gamma_start,
  input  logic [TW-1:0] time_val,
  input  logic [N-1:0]  spike_volley,
  output logic [N-1:0]  out_volley,
  output logic [N-1:0]  win_mask,
  output logic [CW-1:0] win_count,
  output logic [IW-1:0] first_idx,
  output logic [TW-1:0] first_time,
  output logic          first_valid,
  output logic          done
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_INHIBIT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  out_volley_q, out_volley_d;
  logic [N-1:0]  win_mask_q, win_mask_d;
  logic [CW-1:0] win_count_q, win_count_d;
  logic [IW-1:0] first_idx_q, first_idx_d;
  logic [TW-1:0] first_time_q, first_time_d;
  logic          first_valid_q, first_valid_d;
  logic          done_q, done_d;

  // Grant network results for the current cycle.
  logic [N-1:0]  cand;
  logic [N-1:0]  grant;
  logic [IW-1:0] grant_first;
  int            grant_cnt;
  int            slots;
  int            pos;

`ifdef WTA_ROTATE_PRIORITY_EN
  // Index of the neuron that currently has the highest tie-break priority.
  logic [IW-1:0] ptr_q, ptr_d;
`endif

  // Adds this cycle's grants to the winner count, clamping at K.
  function automatic logic [CW-1:0] sat_count(input logic [CW-1:0] cur,
                                              input int add);
    int sum;
    sum = int'(cur) + add;
    if (sum > K) sum = K;
    return CW'(sum);
  endfunction

  // Walk candidates in priority order and grant until the free slots run out.
  always_comb begin
    cand        = spike_volley & ~win_mask_q;
    grant       = '0;
    grant_first = '0;
    grant_cnt   = 0;
    slots       = K - int'(win_count_q);
    pos         = 0;
    for (int i = 0; i < N; i++) begin
`ifdef WTA_ROTATE_PRIORITY_EN
      pos = i + int'(ptr_q);
      if (pos >= N) pos = pos - N;
`else
      pos = i;
`endif
      if (cand[pos] && (grant_cnt < slots)) begin
        grant[pos] = 1'b1;
        if (grant_cnt == 0) grant_first = IW'(pos);
        grant_cnt = grant_cnt + 1;
      end
    end
  end

  // Window FSM and output next-state; gamma_start overrides everything.
  always_comb begin
    state_d       = state_q;
    out_volley_d  = '0;
    win_mask_d    = win_mask_q;
    win_count_d   = win_count_q;
    first_idx_d   = first_idx_q;
    first_time_d  = first_time_q;
    first_valid_d = first_valid_q;
    done_d        = 1'b0;

    if (gamma_start) begin
      // Open a fresh window; spikes in this cycle are deliberately dropped.
      state_d       = ST_ACTIVE;
      win_mask_d    = '0;
      win_count_d   = '0;
      first_idx_d   = '0;
      first_time_d  = '0;
      first_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_ACTIVE: begin
          out_volley_d = grant;
          win_mask_d   = win_mask_q | grant;
          win_count_d  = sat_count(win_count_q, grant_cnt);
          if ((grant_cnt != 0) && !first_valid_q) begin
            first_idx_d   = grant_first;
            first_time_d  = time_val;
            first_valid_d = 1'b1;
          end
          // A spike on the last time step is granted before the window closes.
          if ((int'(win_count_d) == K) || (time_val == TW'(T - 1))) begin
            state_d = ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

`ifdef WTA_ROTATE_PRIORITY_EN
  // Hand top priority to the neuron just after this window's first winner.
  always_comb begin
    ptr_d = ptr_q;
    if (done_d && first_valid_q) begin
      ptr_d = (first_idx_q == IW'(N - 1)) ? '0 : first_idx_q + 1'b1;
    end
  end

  // Priority pointer register, survives across windows.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // State and registered outputs, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q       <= ST_IDLE;
      out_volley_q  <= '0;
      win_mask_q    <= '0;
      win_count_q   <= '0;
      first_idx_q   <= '0;
      first_time_q  <= '0;
      first_valid_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      out_volley_q  <= out_volley_d;
      win_mask_q    <= win_mask_d;
      win_count_q   <= win_count_d;
      first_idx_q   <= first_idx_d;
      first_time_q  <= first_time_d;
      first_valid_q <= first_valid_d;
      done_q        <= done_d;
    end
  end

  assign out_volley  = out_volley_q;
  assign win_mask    = win_mask_q;
  assign win_count   = win_count_q;
  assign first_idx   = first_idx_q;
  assign first_time  = first_time_q;
  assign first_valid = first_valid_q;
  assign done        = done_q;

endmodule
